// File: rtl/cpu_control_unit_pkg.sv
// Shared types for the CPU control unit.
// Opcodes, ALU op codes and FSM state encoding.
package cpu_control_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        ALU_FWD = 3'b000,
        ALU_ADD = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011
    } alu_op_t;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;

    function automatic logic is_legal(input logic [7:0] op);
        return op <= OP_BEQ;
    endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// Bus between the control unit and its datapath neighbours.
// master = control unit, slave = fetch/regfile/ALU side.
interface cpu_control_unit_if #(
    parameter int PC_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int DATA_WIDTH     = 8
);
    logic [31:0]               INSTRUCTION;
    logic                      ZERO;
    logic                      BUSYWAIT;
    logic [PC_WIDTH-1:0]       PC;
    logic [REG_ADDR_WIDTH-1:0] INADDRESS;
    logic [REG_ADDR_WIDTH-1:0] OUT1ADDRESS;
    logic [REG_ADDR_WIDTH-1:0] OUT2ADDRESS;
    logic [DATA_WIDTH-1:0]     IMMEDIATE;
    logic                      WRITE;
    logic [2:0]                ALUOP;
    logic                      MUXSEL_NEG;
    logic                      MUXSEL_IMM;
    logic                      HALTED;
    logic [15:0]               INSTR_COUNT;

    modport master (
        input  INSTRUCTION, ZERO, BUSYWAIT,
        output PC, INADDRESS, OUT1ADDRESS, OUT2ADDRESS,
        output IMMEDIATE, WRITE, ALUOP,
        output MUXSEL_NEG, MUXSEL_IMM, HALTED, INSTR_COUNT
    );

    modport slave (
        output INSTRUCTION, ZERO, BUSYWAIT,
        input  PC, INADDRESS, OUT1ADDRESS, OUT2ADDRESS,
        input  IMMEDIATE, WRITE, ALUOP,
        input  MUXSEL_NEG, MUXSEL_IMM, HALTED, INSTR_COUNT
    );
endinterface

// File: rtl/cpu_control_unit_pc_next_calc.sv
// Next-PC computation: PC+4, branch target, select.
// Purely combinational; reset is applied by the caller.
module pc_next_calc #(
    parameter int PC_WIDTH = 32
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [7:0]          offset,
    input  logic                take,
    input  logic                hold,
    output logic [PC_WIDTH-1:0] pc_next
);
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] off_ext;
    logic [PC_WIDTH-1:0] target;

    assign pc_plus4 = pc + PC_WIDTH'(4);
    assign off_ext  = {{(PC_WIDTH-8){offset[7]}}, offset} << 2;
    assign target   = pc_plus4 + off_ext;

    // Hold beats taken branch beats sequential fetch.
    always_comb begin
        pc_next = pc_plus4;
        if (hold)
            pc_next = pc;
        else if (take)
            pc_next = target;
    end
endmodule

// File: rtl/cpu_control_unit.sv
// CPU control unit: PC, decode, stall/halt FSM.
// Decode is combinational; PC, state and counter register on CLK.
module cpu_control_unit
    import cpu_control_unit_pkg::*;
#(
    parameter int              PC_WIDTH       = 32,
    parameter int              REG_ADDR_WIDTH = 3,
    parameter int              DATA_WIDTH     = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input logic CLK,
    input logic RESET,
    cpu_control_unit_if.master bus
);
    state_t              state_q;
    state_t              state_d;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_next;
    logic [15:0]         cnt_q;

    logic [7:0] op;
    logic       legal;
    logic       wr_op;
    logic       jump;
    logic       branch;
    logic       neg;
    logic       imm;
    alu_op_t    aluop;
    logic       take;
    logic       hold;
    logic       active;
    logic       retire;
    logic       unused_bits;

    assign op    = bus.INSTRUCTION[31:24];
    assign legal = is_legal(op);
    assign unused_bits = ^bus.INSTRUCTION[15:11];

    // Opcode decode into ALU and write controls.
    always_comb begin
        aluop  = ALU_FWD;
        neg    = 1'b0;
        imm    = 1'b0;
        wr_op  = 1'b0;
        jump   = 1'b0;
        branch = 1'b0;
        case (op)
            OP_LOADI: begin wr_op = 1'b1; imm = 1'b1; end
            OP_MOV:   begin wr_op = 1'b1; end
            OP_ADD:   begin wr_op = 1'b1; aluop = ALU_ADD; end
            OP_SUB:   begin
                wr_op = 1'b1;
                aluop = ALU_ADD;
                neg   = 1'b1;
            end
            OP_AND:   begin wr_op = 1'b1; aluop = ALU_AND; end
            OP_OR:    begin wr_op = 1'b1; aluop = ALU_OR; end
            OP_J:     begin jump = 1'b1; end
            OP_BEQ:   begin
                branch = 1'b1;
                aluop  = ALU_ADD;
                neg    = 1'b1;
            end
            default:  ;
        endcase
    end

    assign active = (state_q != ST_HALT) && !bus.BUSYWAIT && !RESET;
    assign retire = active && legal;
    assign take   = jump || (branch && bus.ZERO);
    assign hold   = (state_q == ST_HALT) || bus.BUSYWAIT || !legal;

    pc_next_calc #(.PC_WIDTH(PC_WIDTH)) u_pc_next (
        .pc      (pc_q),
        .offset  (bus.INSTRUCTION[23:16]),
        .take    (take),
        .hold    (hold),
        .pc_next (pc_next)
    );

    // Next-state logic; a pending stall masks an illegal opcode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN, ST_STALL: begin
                if (bus.BUSYWAIT)
                    state_d = ST_STALL;
                else if (!legal)
                    state_d = ST_HALT;
                else
                    state_d = ST_RUN;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    // PC register.
    always_ff @(posedge CLK) begin
        if (RESET)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_next;
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge CLK) begin
        if (RESET)
            cnt_q <= '0;
        else if (retire)
            cnt_q <= cnt_q + 16'd1;
    end

    assign bus.PC          = pc_q;
    assign bus.INADDRESS   = bus.INSTRUCTION[16 +: REG_ADDR_WIDTH];
    assign bus.OUT1ADDRESS = bus.INSTRUCTION[8 +: REG_ADDR_WIDTH];
    assign bus.OUT2ADDRESS = bus.INSTRUCTION[0 +: REG_ADDR_WIDTH];
    assign bus.IMMEDIATE   = bus.INSTRUCTION[0 +: DATA_WIDTH];
    assign bus.WRITE       = wr_op && active;
    assign bus.ALUOP       = aluop;
    assign bus.MUXSEL_NEG  = neg;
    assign bus.MUXSEL_IMM  = imm;
    assign bus.HALTED      = (state_q == ST_HALT);
    assign bus.INSTR_COUNT = cnt_q;
endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed-vector bench for cpu_control_unit.
// Expected values are hand-computed constants.
module tb_cpu_control_unit;
    logic CLK;
    logic RESET;
    int   checks;
    int   failures;

    cpu_control_unit_if bus ();

    cpu_control_unit dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply(input logic [31:0] ins,
                         input logic z,
                         input logic b);
        bus.INSTRUCTION = ins;
        bus.ZERO        = z;
        bus.BUSYWAIT    = b;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RESET    = 1'b1;
        apply(32'h00030055, 1'b0, 1'b0);
        step();
        chk("rst_pc", bus.PC, 0);
        chk("rst_halt", 32'(bus.HALTED), 0);
        chk("rst_cnt", 32'(bus.INSTR_COUNT), 0);
        chk("rst_wr", 32'(bus.WRITE), 0);
        RESET = 1'b0;
        #1;

        chk("ld_rd", 32'(bus.INADDRESS), 3);
        chk("ld_imm", 32'(bus.IMMEDIATE), 32'h55);
        chk("ld_mimm", 32'(bus.MUXSEL_IMM), 1);
        chk("ld_alu", 32'(bus.ALUOP), 0);
        chk("ld_wr", 32'(bus.WRITE), 1);
        step();
        chk("ld_pc", bus.PC, 4);
        chk("ld_cnt", 32'(bus.INSTR_COUNT), 1);

        apply(32'h03050301, 1'b0, 1'b0);
        chk("sub_rd", 32'(bus.INADDRESS), 5);
        chk("sub_rt", 32'(bus.OUT1ADDRESS), 3);
        chk("sub_rs", 32'(bus.OUT2ADDRESS), 1);
        chk("sub_alu", 32'(bus.ALUOP), 1);
        chk("sub_neg", 32'(bus.MUXSEL_NEG), 1);
        chk("sub_imm", 32'(bus.MUXSEL_IMM), 0);
        chk("sub_wr", 32'(bus.WRITE), 1);
        step();
        chk("sub_pc", bus.PC, 8);

        apply(32'h07FE0102, 1'b1, 1'b0);
        chk("beq_wr", 32'(bus.WRITE), 0);
        chk("beq_alu", 32'(bus.ALUOP), 1);
        chk("beq_neg", 32'(bus.MUXSEL_NEG), 1);
        step();
        chk("beq_t_pc", bus.PC, 4);
        chk("beq_t_cnt", 32'(bus.INSTR_COUNT), 3);

        apply(32'h01020100, 1'b0, 1'b0);
        chk("mov_alu", 32'(bus.ALUOP), 0);
        chk("mov_imm", 32'(bus.MUXSEL_IMM), 0);
        chk("mov_wr", 32'(bus.WRITE), 1);
        step();
        chk("mov_pc", bus.PC, 8);

        apply(32'h07FE0102, 1'b0, 1'b0);
        step();
        chk("beq_nt_pc", bus.PC, 12);
        chk("beq_nt_cnt", 32'(bus.INSTR_COUNT), 5);

        apply(32'h04010203, 1'b0, 1'b0);
        chk("and_alu", 32'(bus.ALUOP), 2);
        apply(32'h05010203, 1'b0, 1'b0);
        chk("or_alu", 32'(bus.ALUOP), 3);

        RESET = 1'b1;
        step();
        RESET = 1'b0;
        apply(32'h06FF0000, 1'b0, 1'b0);
        chk("j_wr", 32'(bus.WRITE), 0);
        chk("j_alu", 32'(bus.ALUOP), 0);
        step();
        chk("j_m1_pc", bus.PC, 0);
        chk("j_m1_cnt", 32'(bus.INSTR_COUNT), 1);

        apply(32'h06FE0000, 1'b0, 1'b0);
        step();
        chk("j_wrap_pc", bus.PC, 32'hFFFFFFFC);
        apply(32'h00010001, 1'b0, 1'b0);
        step();
        chk("pc_wrap0", bus.PC, 0);

        apply(32'h06020000, 1'b0, 1'b0);
        step();
        chk("j_fwd_pc", bus.PC, 12);
        chk("j_fwd_cnt", 32'(bus.INSTR_COUNT), 4);

        apply(32'h02040506, 1'b0, 1'b1);
        chk("bw_wr", 32'(bus.WRITE), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bw_pc", bus.PC, 12);
            chk("bw_cnt", 32'(bus.INSTR_COUNT), 4);
            chk("bw_wr_h", 32'(bus.WRITE), 0);
        end
        apply(32'h02040506, 1'b0, 1'b0);
        chk("bw_rel_wr", 32'(bus.WRITE), 1);
        step();
        chk("bw_rel_pc", bus.PC, 16);
        chk("bw_rel_cnt", 32'(bus.INSTR_COUNT), 5);

        apply(32'hFF000000, 1'b0, 1'b1);
        step();
        chk("ill_bw_halt", 32'(bus.HALTED), 0);
        chk("ill_bw_pc", bus.PC, 16);
        apply(32'hFF000000, 1'b0, 1'b0);
        chk("ill_wr", 32'(bus.WRITE), 0);
        step();
        chk("ill_halt", 32'(bus.HALTED), 1);
        chk("ill_pc", bus.PC, 16);
        chk("ill_cnt", 32'(bus.INSTR_COUNT), 5);

        apply(32'h00030055, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("hlt_wr", 32'(bus.WRITE), 0);
            step();
            chk("hlt_pc", bus.PC, 16);
            chk("hlt_flag", 32'(bus.HALTED), 1);
            chk("hlt_cnt", 32'(bus.INSTR_COUNT), 5);
        end

        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk("hrst_pc", bus.PC, 0);
        chk("hrst_halt", 32'(bus.HALTED), 0);
        chk("hrst_cnt", 32'(bus.INSTR_COUNT), 0);

        apply(32'h08000000, 1'b0, 1'b0);
        step();
        chk("op08_halt", 32'(bus.HALTED), 1);
        chk("op08_pc", bus.PC, 0);

        RESET = 1'b1;
        step();
        RESET = 1'b0;
        apply(32'h00010001, 1'b0, 1'b0);
        step();
        apply(32'h00010001, 1'b0, 1'b1);
        step();
        RESET = 1'b1;
        #1;
        chk("rst_bw_wr", 32'(bus.WRITE), 0);
        step();
        RESET = 1'b0;
        apply(32'h00010001, 1'b0, 1'b0);
        chk("rst_bw_pc", bus.PC, 0);
        chk("rst_bw_cnt", 32'(bus.INSTR_COUNT), 0);
        chk("rst_bw_wr1", 32'(bus.WRITE), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
